button_press_classifier: RTL and testbench

BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

---
 rtl/button_press_classifier.sv | 159 +++++++++++++++
 tb/tb_button_press_classifier.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// button_press_classifier
// Classifies a debounced button level into short, long and double press
// pulses. One clock domain, asynchronous active-high reset.
// Optional feature macro: DOUBLE_PRESS_EN. When it is undefined, the
// double-press detection states are not built, a release before the long
// threshold yields short_press directly, and double_press stays 0.
// Timing reference: an "edge" is the rising clk edge that samples a change
// on db. A pulse registered at that edge is visible in the cycle after it.
module button_press_classifier #(
  parameter int LONG_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  // The timer holds (edges since state entry - 1), so a threshold of N
  // cycles is met when the timer reaches N-1.
  localparam logic [26:0] LONG_LAST = 27'(LONG_TICKS - 1);
`ifdef DOUBLE_PRESS_EN
  localparam logic [26:0] GAP_LAST  = 27'(GAP_TICKS - 1);
`endif
  localparam logic [26:0] TIMER_MAX = 27'h7FF_FFFF;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
`ifdef DOUBLE_PRESS_EN
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
`else
    LONG_HELD      = 3'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [26:0] timer;
  logic        db_q;
  logic        rise;
  logic        fall;
  logic        short_next;
  logic        long_next;
  logic        double_next;

  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

  // Previous db sample; resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q <= 1'b1;
    end else begin
      db_q <= db;
    end
  end

  // State register plus the shared saturating timer, cleared on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= 27'd0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        timer <= 27'd0;
      end else if (timer != TIMER_MAX) begin
        timer <= timer + 27'd1;
      end else begin
        timer <= timer;
      end
    end
  end

  // Registered pulse outputs and busy flag, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_press  <= short_next;
      long_press   <= long_next;
      double_press <= double_next;
      busy         <= (state_next != IDLE);
    end
  end

  // Next-state and pulse decode; at most one pulse is requested per cycle.
  always_comb begin
    state_next  = state;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
        end else begin
          state_next = IDLE;
        end
      end
      PRESSED: begin
        if (db && (timer >= LONG_LAST)) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end else if (fall) begin
`ifdef DOUBLE_PRESS_EN
          state_next = WAIT_SECOND;
`else
          short_next = 1'b1;
          state_next = IDLE;
`endif
        end else begin
          state_next = PRESSED;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_next = IDLE;
        end else begin
          state_next = LONG_HELD;
        end
      end
`ifdef DOUBLE_PRESS_EN
      WAIT_SECOND: begin
        // A re-press on the timeout cycle still counts as the second press.
        if (rise) begin
          state_next = SECOND_PRESSED;
        end else if (timer >= GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT_SECOND;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          double_next = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next = SECOND_PRESSED;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Testbench for button_press_classifier with LONG_TICKS=10, GAP_TICKS=6.
// Works for both builds (DOUBLE_PRESS_EN defined or not). A timestamp-based
// model predicts every output each cycle; directed checks pin key timings.
module tb_button_press_classifier;

  localparam int LT = 10;
  localparam int GT = 6;
`ifdef DOUBLE_PRESS_EN
  localparam logic DP = 1'b1;
`else
  localparam logic DP = 1'b0;
`endif

  localparam int M_IDLE   = 0;
  localparam int M_HOLD   = 1;
  localparam int M_LONG   = 2;
  localparam int M_GAP    = 3;
  localparam int M_SECOND = 4;

  logic clk = 1'b0;
  logic reset;
  logic db;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  int total = 0;
  int bad   = 0;

  // model state
  int   m_mode;
  int   m_t0;
  int   m_cyc;
  logic m_prev;
  logic e_short;
  logic e_long;
  logic e_double;
  logic e_busy;

  button_press_classifier #(.LONG_TICKS(LT), .GAP_TICKS(GT)) dut (
    .clk(clk),
    .reset(reset),
    .db(db),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_t0     = 0;
    m_prev   = 1'b1;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    e_busy   = 1'b0;
  endtask

  // One clock edge of the behavioural model: elapsed-time rules on timestamps.
  task automatic model_step();
    logic r;
    logic f;
    m_cyc++;
    r = db & ~m_prev;
    f = ~db & m_prev;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    case (m_mode)
      M_IDLE: if (r) begin m_mode = M_HOLD; m_t0 = m_cyc; end
      M_HOLD: begin
        if (db && (m_cyc - m_t0 == LT)) begin
          e_long = 1'b1; m_mode = M_LONG;
        end else if (f) begin
          if (DP) begin m_mode = M_GAP; m_t0 = m_cyc; end
          else begin e_short = 1'b1; m_mode = M_IDLE; end
        end
      end
      M_LONG: if (f) m_mode = M_IDLE;
      M_GAP: begin
        if (r) m_mode = M_SECOND;
        else if (m_cyc - m_t0 == GT) begin e_short = 1'b1; m_mode = M_IDLE; end
      end
      M_SECOND: if (f) begin e_double = 1'b1; m_mode = M_IDLE; end
      default: m_mode = M_IDLE;
    endcase
    m_prev = db;
    e_busy = (m_mode != M_IDLE);
  endtask

  task automatic check_all();
    chk("m_short", short_press, e_short);
    chk("m_long", long_press, e_long);
    chk("m_double", double_press, e_double);
    chk("m_busy", busy, e_busy);
  endtask

  // Advance n cycles: model steps on the rising edge, compare on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("rst_busy", busy, 1'b0);
    chk("rst_short", short_press, 1'b0);
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    int sd;
    sd = DP ? 7 : 1;  // cycles from release to visible short_press
    m_cyc = 0;
    db    = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    do_reset(2);
    tick(3);

    // short press: 4 cycles high
    db = 1'b1; tick(4);
    db = 1'b0; tick(sd - 1);
    chk("short_early", short_press, 1'b0);
    tick(1);
    chk("short_pulse", short_press, 1'b1);
    tick(1);
    chk("short_once", short_press, 1'b0);
    chk("short_idle", busy, 1'b0);
    tick(5);

    // long press: 25 cycles high
    db = 1'b1; tick(LT);
    chk("long_early", long_press, 1'b0);
    tick(1);
    chk("long_pulse", long_press, 1'b1);
    tick(1);
    chk("long_once", long_press, 1'b0);
    tick(13);
    chk("long_busy", busy, 1'b1);
    db = 1'b0; tick(1);
    chk("long_rel_busy", busy, 1'b0);
    chk("long_rel_pulse", long_press, 1'b0);
    tick(8);

    // double press: high 3, low 3, high 3, low
    db = 1'b1; tick(3);
    db = 1'b0; tick(3);
    db = 1'b1; tick(3);
    db = 1'b0; tick(1);
    chk("dbl_pulse", double_press, DP);
    chk("dbl_short", short_press, ~DP);
    tick(10);

    // gap timeout: release sampled for 7 edges, then an independent press
    db = 1'b1; tick(3);
    db = 1'b0; tick(7);
    chk("gap_short", short_press, DP);
    db = 1'b1; tick(4);
    db = 1'b0; tick(sd - 1);
    chk("gap2_early", short_press, 1'b0);
    tick(1);
    chk("gap2_short", short_press, 1'b1);
    tick(10);

    // re-press sampled on the timeout edge: the re-press wins
    db = 1'b1; tick(3);
    db = 1'b0; tick(6);
    db = 1'b1; tick(1);
    chk("tie_no_short", short_press, 1'b0);
    chk("tie_busy", busy, 1'b1);
    tick(2);
    db = 1'b0; tick(1);
    chk("tie_double", double_press, DP);
    tick(10);

    // held through reset release: no press
    db = 1'b1;
    do_reset(2);
    tick(3);
    chk("held_busy", busy, 1'b0);
    db = 1'b0; tick(3);
    chk("held_rel_busy", busy, 1'b0);
    db = 1'b1; tick(4);
    db = 1'b0; tick(sd);
    chk("after_held_short", short_press, 1'b1);
    tick(10);

    // reset in the gap between presses discards the event
    db = 1'b1; tick(3);
    db = 1'b0; tick(2);
    chk("pre_rst_busy", busy, DP);
    do_reset(2);
    tick(12);

    // reset mid long press with button still held: no long pulse
    db = 1'b1; tick(5);
    do_reset(2);
    tick(15);
    chk("rst_long_none", long_press, 1'b0);
    db = 1'b0; tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
